// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types: the {pc, instr} entry handed to decode and the
// architectural reset vector used as the first fetch address.
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_q_entry_t;

  localparam word_t FETCH_RESET_PC = 32'hbfc0_0000;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for a circular buffer of DEPTH
// entries; storage lives in the parent. A synchronous clear empties it.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Explicit wrap keeps non-power-of-two depths (e.g. MAX_OUT=3) correct.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues SRAM-like requests with bounded outstanding
// count, buffers {pc, instr} pairs, and squashes everything on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter int    MAX_OUT  = 2,
  parameter word_t RESET_PC = FETCH_RESET_PC
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic                         i_req,
  output word_t                        i_addr,
  input  logic                         i_addr_ok,
  input  logic                         i_data_ok,
  input  word_t                        i_rdata,
  input  logic                         redirect,
  input  word_t                        redirect_pc,
  output logic                         deq_valid,
  output word_t                        deq_pc,
  output word_t                        deq_instr,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QA = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FA = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = CW + OW + 1;

  word_t          next_pc_q;
  word_t          req_addr_q;
  logic           req_lock_q;
  logic           lock_stale_q;
  logic [OW-1:0]  discard_cnt;
  logic [OW-1:0]  out_cnt;
  logic [OW-1:0]  out_cnt_next;

  logic [FA-1:0]  infl_wr, infl_rd;
  logic           infl_empty, infl_full;
  logic [QA-1:0]  q_wr, q_rd;
  logic           q_empty, q_full;

  word_t          infl_mem [MAX_OUT];
  fetch_q_entry_t q_mem    [DEPTH];

  logic           accept, resp, keep, deq, credit_ok;
  logic [SW-1:0]  occupied;

  // Entries already queued plus responses still expected to be kept.
  assign occupied  = SW'(count) + SW'(out_cnt) - SW'(discard_cnt);
  assign credit_ok = occupied < SW'(DEPTH);

  assign i_req  = req_lock_q | (!redirect & !infl_full & credit_ok);
  assign i_addr = req_lock_q ? req_addr_q : next_pc_q;

  assign accept       = i_req & i_addr_ok;
  assign resp         = i_data_ok & !infl_empty;
  assign keep         = resp & (discard_cnt == '0) & !redirect;
  assign deq          = !q_empty & deq_ready;
  assign out_cnt_next = out_cnt + OW'(accept) - OW'(resp);

  assign deq_valid = !q_empty;
  assign deq_pc    = deq_valid ? q_mem[q_rd].pc    : '0;
  assign deq_instr = deq_valid ? q_mem[q_rd].instr : '0;

  fifo_ptr_ctrl #(.DEPTH(MAX_OUT)) u_inflight (
    .clk    (clk),
    .resetn (resetn),
    .clr    (1'b0),
    .push   (accept),
    .pop    (resp),
    .wr_ptr (infl_wr),
    .rd_ptr (infl_rd),
    .count  (out_cnt),
    .empty  (infl_empty),
    .full   (infl_full)
  );

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_queue (
    .clk    (clk),
    .resetn (resetn),
    .clr    (redirect),
    .push   (keep),
    .pop    (deq),
    .wr_ptr (q_wr),
    .rd_ptr (q_rd),
    .count  (count),
    .empty  (q_empty),
    .full   (q_full)
  );

  // A request held across a redirect is marked stale so its eventual
  // acceptance is counted as one more response to throw away.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      next_pc_q    <= RESET_PC;
      req_addr_q   <= '0;
      req_lock_q   <= 1'b0;
      lock_stale_q <= 1'b0;
      discard_cnt  <= '0;
    end else begin
      if (accept) begin
        req_lock_q   <= 1'b0;
        lock_stale_q <= 1'b0;
        if (!req_lock_q) next_pc_q <= i_addr + 32'd4;
      end else if (i_req) begin
        req_lock_q <= 1'b1;
        req_addr_q <= i_addr;
      end
      if (redirect) begin
        next_pc_q    <= redirect_pc;
        lock_stale_q <= req_lock_q & !i_addr_ok;
        discard_cnt  <= out_cnt_next;
      end else begin
        discard_cnt <= discard_cnt - OW'(resp && (discard_cnt != '0))
                                   + OW'(accept && lock_stale_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) infl_mem[infl_wr] <= i_addr;
    if (keep)   q_mem[q_wr]       <= '{pc: infl_mem[infl_rd], instr: i_rdata};
  end

  a_no_orphan_response: assert property (@(posedge clk) disable iff (!resetn)
    !(i_data_ok && infl_empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(keep && q_full && !deq));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       i_req;
  word_t      i_addr;
  logic       i_addr_ok = 1'b0;
  logic       i_data_ok = 1'b0;
  word_t      i_rdata = '0;
  logic       redirect = 1'b0;
  word_t      redirect_pc = '0;
  logic       deq_valid;
  word_t      deq_pc;
  word_t      deq_instr;
  logic       deq_ready = 1'b0;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  word_t m_q_pc[$];
  word_t m_q_in[$];
  word_t m_fl_pc[$];
  bit    m_fl_keep[$];
  bit    m_lock;
  bit    m_stale;
  word_t m_lock_addr;
  word_t m_npc;
  bit    exp_req;
  word_t exp_addr;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_addr_ok   (i_addr_ok),
    .i_data_ok   (i_data_ok),
    .i_rdata     (i_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_valid   (deq_valid),
    .deq_pc      (deq_pc),
    .deq_instr   (deq_instr),
    .deq_ready   (deq_ready),
    .count       (count)
  );

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kept_in_flight();
    int n = 0;
    foreach (m_fl_keep[i]) if (m_fl_keep[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_q_pc.delete();
    m_q_in.delete();
    m_fl_pc.delete();
    m_fl_keep.delete();
    m_lock  = 1'b0;
    m_stale = 1'b0;
    m_npc   = FETCH_RESET_PC;
  endtask

  // Compare the DUT against the model for the current cycle's inputs.
  task automatic checkOutput();
    exp_req  = m_lock || (!redirect && m_fl_pc.size() < MAX_OUT &&
                          m_q_pc.size() + kept_in_flight() < DEPTH);
    exp_addr = m_lock ? m_lock_addr : m_npc;
    expect_val("i_req", 32'(i_req), 32'(exp_req));
    expect_val("i_addr", i_addr, exp_addr);
    expect_val("deq_valid", 32'(deq_valid), 32'(m_q_pc.size() > 0));
    expect_val("count", 32'(count), 32'(m_q_pc.size()));
    if (m_q_pc.size() > 0) begin
      expect_val("deq_pc", deq_pc, m_q_pc[0]);
      expect_val("deq_instr", deq_instr, m_q_in[0]);
    end
  endtask

  task automatic applyStimulus(input bit aok, input bit dok, input word_t rdata,
                               input bit redir, input word_t rpc, input bit rdy);
    i_addr_ok   = aok;
    i_data_ok   = dok;
    i_rdata     = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    deq_ready   = rdy;
    #1;
    checkOutput();
  endtask

  // Advance the model across the coming clock edge, then wait for the next cycle.
  task automatic finishCycle();
    bit acc, rsp, dq, rk;
    word_t rp;
    acc = exp_req && i_addr_ok;
    rsp = i_data_ok && m_fl_pc.size() > 0;
    dq  = m_q_pc.size() > 0 && deq_ready;
    if (dq) begin
      void'(m_q_pc.pop_front());
      void'(m_q_in.pop_front());
    end
    if (rsp) begin
      rp = m_fl_pc.pop_front();
      rk = m_fl_keep.pop_front();
      if (rk && !redirect) begin
        m_q_pc.push_back(rp);
        m_q_in.push_back(i_rdata);
      end
    end
    if (acc) begin
      m_fl_pc.push_back(exp_addr);
      m_fl_keep.push_back(!(m_lock && m_stale));
      if (!m_lock) m_npc = exp_addr + 32'd4;
      m_lock  = 1'b0;
      m_stale = 1'b0;
    end else if (exp_req) begin
      m_lock      = 1'b1;
      m_lock_addr = exp_addr;
    end
    if (redirect) begin
      m_q_pc.delete();
      m_q_in.delete();
      foreach (m_fl_keep[i]) m_fl_keep[i] = 1'b0;
      m_npc = redirect_pc;
      if (m_lock) m_stale = 1'b1;
    end
    @(negedge clk);
  endtask

  // Entered and left on a falling edge; reset is checked while still asserted.
  task automatic doReset();
    resetn    = 1'b0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    redirect  = 1'b0;
    deq_ready = 1'b0;
    #1;
    expect_val("rst_i_req", 32'(i_req), 32'd1);
    expect_val("rst_i_addr", i_addr, 32'hbfc0_0000);
    expect_val("rst_deq_valid", 32'(deq_valid), 32'd0);
    expect_val("rst_deq_pc", deq_pc, 32'd0);
    expect_val("rst_deq_instr", deq_instr, 32'd0);
    expect_val("rst_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  function automatic bit dok_rand(input int pct_num);
    return m_fl_pc.size() > 0 && ($urandom_range(3) < pct_num);
  endfunction

  initial begin
    @(negedge clk);
    doReset();

    // Streaming: one instruction per cycle once the pipe fills.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, m_fl_pc.size() > 0, $urandom, 1'b0, '0, 1'b1);
      if (k == 0) expect_val("stream_first_addr", i_addr, 32'hbfc0_0000);
      if (k >= 2) begin
        expect_val("stream_valid", 32'(deq_valid), 32'd1);
        expect_val("stream_pc", deq_pc, 32'hbfc0_0000 + 32'(4 * (k - 2)));
      end
      finishCycle();
    end

    // Backpressure then drain.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, m_fl_pc.size() > 0, $urandom, 1'b0, '0, 1'b0);
      finishCycle();
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    expect_val("bp_count_sat", 32'(count), 32'd4);
    expect_val("bp_req_low", 32'(i_req), 32'd0);
    finishCycle();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, m_fl_pc.size() > 0, $urandom, 1'b0, '0, 1'b1);
      finishCycle();
    end

    // Redirect with two requests in flight.
    doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b1, 1'b1, 32'h1111_0000, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 32'h8000_1000, 1'b0);
    expect_val("redir_head_kept", 32'(deq_valid), 32'd1);
    expect_val("redir_req_low", 32'(i_req), 32'd0);
    finishCycle();
    applyStimulus(1'b1, 1'b1, 32'hdead_0001, 1'b0, '0, 1'b0);
    expect_val("redir_count_cleared", 32'(count), 32'd0);
    finishCycle();
    applyStimulus(1'b1, 1'b1, 32'hdead_0002, 1'b0, '0, 1'b0);
    expect_val("redir_new_req", 32'(i_req), 32'd1);
    expect_val("redir_new_addr", i_addr, 32'h8000_1000);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 32'hcafe_0001, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    expect_val("redir_deq_pc", deq_pc, 32'h8000_1000);
    expect_val("redir_deq_instr", deq_instr, 32'hcafe_0001);
    finishCycle();

    // Locked request held across a redirect.
    doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h8000_1000, 1'b0);
    expect_val("lock_hold_redir", i_addr, 32'hbfc0_0000);
    expect_val("lock_req_redir", 32'(i_req), 32'd1);
    finishCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    expect_val("lock_hold", i_addr, 32'hbfc0_0000);
    finishCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    expect_val("lock_next_addr", i_addr, 32'h8000_1000);
    finishCycle();
    applyStimulus(1'b0, 1'b1, 32'hdead_beef, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, '0, 1'b0); finishCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    expect_val("lock_deq_pc", deq_pc, 32'h8000_1000);
    expect_val("lock_deq_instr", deq_instr, 32'h1234_5678);
    finishCycle();

    // Async reset mid-stream with three entries queued.
    doReset();
    for (int k = 0; k < 20 && m_q_pc.size() < 3; k++) begin
      applyStimulus(1'b1, m_fl_pc.size() > 0, $urandom, 1'b0, '0, 1'b0);
      finishCycle();
    end
    expect_val("prereset_count", 32'(count), 32'd3);
    doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    expect_val("postreset_addr", i_addr, 32'hbfc0_0000);
    finishCycle();

    // Random traffic, including redirects that coincide with accepts/responses.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) doReset();
      applyStimulus($urandom_range(3) != 0, dok_rand(3), $urandom,
                    $urandom_range(15) == 0, $urandom, $urandom_range(3) != 0);
      finishCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
